// File: rtl/mult_pkg.sv
// Shared types and constants for the signed add-shift multiplier datapath.
package mult_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CLR,
    OP_SUB,
    OP_ADD,
    OP_SHIFT
  } op_t;

  // Fixed priority: load > clear > sub > add > shift > hold.
  function automatic op_t decode_op(input logic load_b, input logic clr_xa,
                                    input logic sub_en, input logic add_en,
                                    input logic shift_en);
    if (load_b)        return OP_LOAD;
    else if (clr_xa)   return OP_CLR;
    else if (sub_en)   return OP_SUB;
    else if (add_en)   return OP_ADD;
    else if (shift_en) return OP_SHIFT;
    else               return OP_HOLD;
  endfunction

endpackage

// File: rtl/add_sub9.sv
// (N)-bit two's-complement adder/subtractor; sub=1 computes a - b.
module add_sub9 #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  always_comb begin
    sum = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};
  end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B register datapath of the 8-bit signed add-shift multiplier.
// Optional protocol checker output proto_err under `MULT_DP_PROTO_CHK_EN.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             load_b,
  input  logic             clr_xa,
  input  logic             add_en,
  input  logic             sub_en,
  input  logic             shift_en,
  output logic             Xval,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M,
  output logic             done
`ifdef MULT_DP_PROTO_CHK_EN
  ,
  output logic             proto_err
`endif
);

  localparam int unsigned CNT_BITS = $clog2(WIDTH + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(WIDTH);

  op_t                op;
  logic [WIDTH:0]     sum;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;

  always_comb begin
    op      = decode_op(load_b, clr_xa, sub_en, add_en, shift_en);
    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    M       = Bval[0];
  end

  add_sub9 #(.N(WIDTH + 1)) u_add_sub9 (
    .a   ({Aval[WIDTH-1], Aval}),
    .b   ({Din[WIDTH-1], Din}),
    .sub (op == OP_SUB),
    .sum (sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Xval <= 1'b0;
      Aval <= '0;
      Bval <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      unique case (op)
        OP_LOAD: begin
          Bval <= Din;
          Xval <= 1'b0;
          Aval <= '0;
          cnt  <= '0;
          done <= 1'b0;
        end
        OP_CLR: begin
          Xval <= 1'b0;
          Aval <= '0;
          cnt  <= '0;
          done <= 1'b0;
        end
        OP_SUB, OP_ADD: begin
          if (M) begin
            Xval <= sum[WIDTH];
            Aval <= sum[WIDTH-1:0];
          end
        end
        OP_SHIFT: begin
          Aval <= {Xval, Aval[WIDTH-1:1]};
          Bval <= {Aval[0], Bval[WIDTH-1:1]};
          cnt  <= cnt_nxt;
          done <= done | (cnt_nxt == CNT_MAX);
        end
        OP_HOLD: ;
        default: ;
      endcase
    end
  end

`ifdef MULT_DP_PROTO_CHK_EN
  logic proto_viol;

  // A violating load_b still leaves the flag set.
  always_comb begin
    proto_viol = ($countones({load_b, clr_xa, add_en, sub_en, shift_en}) > 1)
               | (done & (add_en | sub_en | shift_en));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) proto_err <= 1'b0;
    else          proto_err <= (load_b ? 1'b0 : proto_err) | proto_viol;
  end
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed scoreboard bench for mult_datapath (optionally with MULT_DP_PROTO_CHK_EN).
module tb_mult_datapath;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] Din;
  logic       load_b, clr_xa, add_en, sub_en, shift_en;
  logic       Xval, M, done;
  logic [7:0] Aval, Bval;
`ifdef MULT_DP_PROTO_CHK_EN
  logic       proto_err;
`endif

  mult_datapath #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Din      (Din),
    .load_b   (load_b),
    .clr_xa   (clr_xa),
    .add_en   (add_en),
    .sub_en   (sub_en),
    .shift_en (shift_en),
    .Xval     (Xval),
    .Aval     (Aval),
    .Bval     (Bval),
    .M        (M),
    .done     (done)
`ifdef MULT_DP_PROTO_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    bit         dv;
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
    logic       dn;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_pe = 1'b0;

  task automatic push_exp(input string tag, input bit dv, input logic x,
                          input logic [7:0] a, input logic [7:0] b, input logic dn);
    exp_t e;
    e.tag = tag; e.dv = dv; e.x = x; e.a = a; e.b = b; e.dn = dn; e.pe = exp_pe;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got size %0d, required > 0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dv) begin
        checks++;
        assert (Xval === e.x) else begin
          errors++; $error("FAIL %s X: got %0b, required %0b", e.tag, Xval, e.x);
        end
        checks++;
        assert (Aval === e.a) else begin
          errors++; $error("FAIL %s A: got %02h, required %02h", e.tag, Aval, e.a);
        end
        checks++;
        assert (Bval === e.b) else begin
          errors++; $error("FAIL %s B: got %02h, required %02h", e.tag, Bval, e.b);
        end
        checks++;
        assert (M === e.b[0]) else begin
          errors++; $error("FAIL %s M: got %0b, required %0b", e.tag, M, e.b[0]);
        end
      end
      checks++;
      assert (done === e.dn) else begin
        errors++; $error("FAIL %s done: got %0b, required %0b", e.tag, done, e.dn);
      end
`ifdef MULT_DP_PROTO_CHK_EN
      checks++;
      assert (proto_err === e.pe) else begin
        errors++; $error("FAIL %s proto_err: got %0b, required %0b", e.tag, proto_err, e.pe);
      end
`endif
    end
  endtask

  // Apply one cycle of strobes, released 1 time unit after the edge.
  task automatic cyc(input logic lb, input logic cx, input logic ad,
                     input logic sb_, input logic sh);
    load_b = lb; clr_xa = cx; add_en = ad; sub_en = sb_; shift_en = sh;
    @(posedge Clk);
    #1;
    load_b = 0; clr_xa = 0; add_en = 0; sub_en = 0; shift_en = 0;
  endtask

  // Nominal control sequence; expected product from a plain signed multiply.
  task automatic run_mult(input string tag, input logic [7:0] mplier, input logic [7:0] mcand);
    logic signed [15:0] p;
    p = $signed(mplier) * $signed(mcand);
    Din = mcand;
    for (int unsigned i = 0; i < 7; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
    end
    push_exp({tag, "_7sh"}, 0, 0, '0, '0, 1'b0);
    check_out();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    push_exp(tag, 1, p[15], p[15:8], p[7:0], 1'b1);
    check_out();
  endtask

  initial begin
    Din = '0; load_b = 0; clr_xa = 0; add_en = 0; sub_en = 0; shift_en = 0;
    Reset_n = 1'b0;
    #2;
    push_exp("por", 1, 0, 8'h00, 8'h00, 0);
    check_out();
    #10 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Async reset in the middle of a multiply, checked before the next edge.
    Din = 8'hFD; cyc(1, 0, 0, 0, 0);
    Din = 8'h07; cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    push_exp("pre_rst", 1, 0, 8'h03, 8'hFE, 0);
    check_out();
    #2 Reset_n = 1'b0;
    #1;
    push_exp("async_rst", 1, 0, 8'h00, 8'h00, 0);
    check_out();
    #2 Reset_n = 1'b1;

    // -3 * 7 = -21
    Din = 8'hFD; cyc(1, 0, 0, 0, 0);
    push_exp("load_fd", 1, 0, 8'h00, 8'hFD, 0);
    check_out();
    run_mult("m3x7", 8'hFD, 8'h07);

    // Shifting past done keeps shifting and keeps done; flags a protocol error.
    cyc(0, 0, 0, 0, 1);
    exp_pe = 1'b1;
    push_exp("shift_after_done", 1, 1, 8'hFF, 8'hF5, 1);
    check_out();
    for (int unsigned i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    push_exp("sat_done", 1, 1, 8'hFF, 8'hFF, 1);
    check_out();

    // -128 * -128 = 16384, then clear and 0 * 2 with B kept
    Din = 8'h80; cyc(1, 0, 0, 0, 0);
    exp_pe = 1'b0;
    push_exp("load_80", 1, 0, 8'h00, 8'h80, 0);
    check_out();
    run_mult("m80x80", 8'h80, 8'h80);
    Din = 8'h02; cyc(0, 1, 0, 0, 0);
    push_exp("clr_keep_b", 1, 0, 8'h00, 8'h00, 0);
    check_out();
    run_mult("m0x2", 8'h00, 8'h02);

    // Single add / sub with M=1 from A=0
    Din = 8'h01; cyc(1, 0, 0, 0, 0);
    Din = 8'h80; cyc(0, 0, 1, 0, 0);
    push_exp("add_80", 1, 1, 8'h80, 8'h01, 0);
    check_out();
    Din = 8'h01; cyc(1, 0, 0, 0, 0);
    Din = 8'h80; cyc(0, 0, 0, 1, 0);
    push_exp("sub_80", 1, 0, 8'h80, 8'h01, 0);
    check_out();

    // M=0: add/sub ignored, shift still counts
    Din = 8'h02; cyc(1, 0, 0, 0, 0);
    Din = 8'h55; cyc(0, 0, 1, 0, 0);
    push_exp("add_m0", 1, 0, 8'h00, 8'h02, 0);
    check_out();
    cyc(0, 0, 0, 1, 0);
    push_exp("sub_m0", 1, 0, 8'h00, 8'h02, 0);
    check_out();
    cyc(0, 0, 0, 0, 1);
    push_exp("shift_m0", 1, 0, 8'h00, 8'h01, 0);
    check_out();

    // Simultaneous strobes: priority applies, checker flag is sticky until load
    Din = 8'h01; cyc(1, 0, 0, 0, 0);
    Din = 8'h03; cyc(0, 0, 1, 0, 1);
    exp_pe = 1'b1;
    push_exp("add_shift", 1, 0, 8'h03, 8'h01, 0);
    check_out();
    cyc(0, 0, 0, 0, 0);
    push_exp("hold_sticky", 1, 0, 8'h03, 8'h01, 0);
    check_out();
    cyc(0, 1, 0, 1, 0);
    push_exp("clr_over_sub", 1, 0, 8'h00, 8'h01, 0);
    check_out();
    Din = 8'h02; cyc(1, 0, 0, 0, 0);
    exp_pe = 1'b0;
    push_exp("load_clears", 1, 0, 8'h00, 8'h02, 0);
    check_out();

    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Register/arithmetic datapath of the 8-bit signed add-shift multiplier.
- Sits directly downstream of the multiplier control FSM and consumes its add_en / sub_en / shift_en strobes.
- Holds X (sign extension bit), A (accumulator / high byte) and B (multiplier / low byte).
- S (multiplicand) is taken live from the switch input Din.
- Tracks completed shifts and flags when the 2W-bit product {A,B} is final.

Parameters:
- WIDTH, 8, operand width of A, B, S. The adder is WIDTH+1 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Din  in  WIDTH  switch value; B load source and multiplicand S.
- load_b  in  1  load B from Din and clear X, A, shift count.
- clr_xa  in  1  clear X, A, shift count; B is kept (consecutive multiply).
- add_en  in  1  conditional add strobe from control.
- sub_en  in  1  conditional subtract strobe from control.
- shift_en  in  1  arithmetic right shift strobe from control.
- Xval  out  1  X register.
- Aval  out  WIDTH  A register.
- Bval  out  WIDTH  B register.
- M  out  1  B[0], combinational.
- done  out  1  registered; high once WIDTH shifts have completed since the last clear/load.

Behaviour:
- Reset (Reset_n low, async): X=0, A=0, B=0, shift count=0, done=0. Asserting reset mid-multiply aborts immediately with no partial update.
- Per-cycle operation priority, exactly one applied: load_b > clr_xa > sub_en > add_en > shift_en > hold.
- load_b: B<=Din, X<=0, A<=0, cnt<=0, done<=0.
- clr_xa: X<=0, A<=0, cnt<=0, done<=0. B unchanged.
- add_en with M=1: sum = {A[W-1],A} + {Din[W-1],Din}, a W+1-bit result. X<=sum[W], A<=sum[W-1:0].
- add_en with M=0: no change.
- sub_en with M=1: sum = {A[W-1],A} + ~{Din[W-1],Din} + 1. Update X and A as for add.
- sub_en with M=0: no change.
- Arithmetic wraps silently at W+1 bits; no overflow flag.
- shift_en: X<=X, A<={X,A[W-1:1]}, B<={A[0],B[W-1:1]}, cnt<=cnt+1 saturating at WIDTH.
- done<=1 in the same edge that cnt reaches WIDTH. done stays high until the next clr_xa, load_b or reset. Further shifts after done still shift the registers; cnt stays at WIDTH.
- Latency: every operation is visible on the outputs the cycle after the strobe edge. M follows Bval combinationally.
- Nominal sequence from control: 7 adds and 1 sub interleaved with 8 shifts (add/shift pairs, then sub/shift). Any enable pattern must be tolerated per the priority rule.

Optional Feature:
- Macro: MULT_DP_PROTO_CHK_EN.
- Defined: adds output proto_err (1 bit).
  - Sticky; set on any cycle where more than one of {load_b, clr_xa, add_en, sub_en, shift_en} is high.
  - Also set on any add_en/sub_en/shift_en after done=1.
  - Cleared only by reset or load_b.
  - Data behaviour is unchanged (priority still applies).
- Undefined: no proto_err port and no checker logic.

Decomposition:
- Shared package mult_pkg:
  - localparam WIDTH=8.
  - Enum op_t {OP_HOLD, OP_LOAD, OP_CLR, OP_SUB, OP_ADD, OP_SHIFT} used for priority decode.
  - Shift-count width constant $clog2(WIDTH+1).
- One sub-module: add_sub9. It is a (WIDTH+1)-bit adder/subtractor with inputs a, b, sub and output sum, and is instantiated once.

Test Plan:
- Reset_n low while registers nonzero -> X=0, A=0x00, B=0x00, done=0 asynchronously, before the next Clk edge.
- load_b with Din=0xFD, then Din=0x07, run the full control sequence -> after 8 shifts X=1, A=0xFF, B=0xEB (-21), done=1.
- load_b Din=0x80, Din=0x80, full sequence -> A=0x40, B=0x00, X=0 (16384); then clr_xa, Din=0x02, full sequence -> {A,B}=0x0000 (0x00*2), B preserved before the run.
- A=0, B=0x01, Din=0x80: single add_en -> X=1, A=0x80; from A=0, a single sub_en instead -> X=0, A=0x80.
- B=0x02 (M=0), add_en and sub_en pulses -> X/A unchanged; shift_en -> B=0x01, cnt=1, done=0.
- add_en and shift_en asserted together -> only the add is applied. With MULT_DP_PROTO_CHK_EN, proto_err=1 and stays high until load_b.
